ma_mem_stage: RTL and testbench
===============================

MA_MEM_STAGE -- requirements
Module: ma_mem_stage

Interface
REQ-001 SHALL have parameters: DATA_W, 32, datapath width, 32 or 64; ADDR_W, 32, byte-address width; REG_ADDR_W, 5, register-file index width.
REQ-002 SHALL have one clock and an asynchronous, active-low reset; reset asserts immediately, deasserts on clk.
REQ-003 ports, in order:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous active-low reset.
- halt  in  1  freeze output register and acceptance.
- flush  in  1  squash the instruction presented this cycle.
- is_mem_in  in  1  instruction is a load/store.
- is_load_in  in  1  1=load, 0=store.
- mem_size_in  in  2  00 byte, 01 half, 10 word; 11 reserved, treated as word.
- mem_signed_in  in  1  sign-extend load result.
- mem_addr_in  in  ADDR_W  byte address.
- store_data_in  in  DATA_W  store data, right-justified.
- is_int_wb_in  in  1  writeback valid.
- int_wb_address_in  in  REG_ADDR_W  destination register.
- int_wb_value_in  in  DATA_W  ALU result.
- dmem_req  out  1  bus request, registered.
- dmem_we  out  1  1=write.
- dmem_addr  out  ADDR_W  address aligned to DATA_W/8 bytes.
- dmem_wdata  out  DATA_W  lane-replicated store data.
- dmem_be  out  DATA_W/8  byte enables.
- dmem_rdata  in  DATA_W  read data, valid with ack.
- dmem_ack  in  1  one-cycle completion strobe.
- stall_out  out  1  upstream must hold.
- is_mem_out  out  1  memory op retired.
- is_int_wb_out  out  1  writeback valid.
- int_wb_address_out  out  REG_ADDR_W  destination register.
- int_wb_value_out  out  DATA_W  writeback value.
- misalign_out  out  1  present only with MA_MISALIGN_TRAP_EN.

Function
REQ-004 SHALL implement states IDLE, ACCESS and DONE.
REQ-005 IDLE, halt=0, flush=1: SHALL load a bubble, all output flags 0.
REQ-006 IDLE, halt=0, flush=0, is_mem_in=0: SHALL copy the wb inputs to the outputs with is_mem_out=0; latency 1 cycle.
REQ-007 IDLE, halt=0, flush=0, is_mem_in=1: SHALL latch the request, load a bubble, set dmem_req=1 and go to ACCESS.
REQ-008 dmem_req, dmem_we, dmem_addr, dmem_wdata and dmem_be SHALL hold stable in ACCESS until the edge after dmem_ack.
REQ-009 stall_out SHALL equal (state != IDLE); inputs SHALL be ignored while it is 1.
REQ-010 ACCESS: the output register SHALL load a bubble on every edge without ack.
REQ-011 ACCESS with dmem_ack: SHALL drop dmem_req and retire. With halt=0 it SHALL write the result and go to IDLE; with halt=1 it SHALL buffer the result and go to DONE.
REQ-012 DONE SHALL write the buffered result on the first edge with halt=0, then go to IDLE.
REQ-013 Retire SHALL set is_mem_out=1. A load SHALL set is_int_wb_out=1 with its latched destination. A store SHALL set is_int_wb_out=0 and int_wb_address_out=0.
REQ-014 The lane SHALL be mem_addr_in[log2(DATA_W/8)-1:0]. A load SHALL extract 8/16/32 bits at the lane and zero- or sign-extend them to DATA_W per mem_signed_in.
REQ-015 A store SHALL replicate the data across lanes and set dmem_be to 1/2/4 bits at the lane.
REQ-016 halt in IDLE SHALL freeze all outputs and state. flush SHALL be ignored outside IDLE; an issued access always retires.

Reset
REQ-017 While reset=0: state SHALL be IDLE and every output, including dmem_* and misalign_out, SHALL be 0.
REQ-018 Reset mid-ACCESS SHALL abandon the transaction; an ack arriving after reset release in IDLE SHALL be ignored.

Configuration
REQ-019 With MA_MISALIGN_TRAP_EN defined: a half access with addr[0]=1, or a word access with addr[1:0]!=0, SHALL issue no request, SHALL load a bubble with misalign_out=1 for one cycle, and SHALL stay in IDLE.
REQ-020 Without MA_MISALIGN_TRAP_EN: misalign_out SHALL be absent, and address bits below the access size SHALL be forced to 0.

Verification
REQ-021 ALU op, wb r5=0x1234 -> next edge is_int_wb_out=1, address 5, value 0x1234, is_mem_out=0.
REQ-022 lb at 0x103, rdata 0x80xxxxxx, signed, ack 3 cycles after req -> stall_out high 4 cycles, value 0xFFFFFF80, then lbu gives 0x00000080.
REQ-023 sh 0xBEEF at 0x102 -> dmem_be=4'b1100, dmem_wdata=0xBEEFBEEF, retire with is_int_wb_out=0, is_mem_out=1.
REQ-024 halt=1 during the ack cycle, held 2 cycles -> DONE, result appears on the first unhalted edge.
REQ-025 flush with a load presented -> no dmem_req, bubble out. Reset pulse in ACCESS -> all outputs 0 asynchronously, IDLE.
REQ-026 With MA_MISALIGN_TRAP_EN, lw at 0x102 -> misalign_out=1 for one cycle, no request. Without it -> request at 0x100.

Source files
------------

// File: rtl/ma_mem_stage.sv
// ma_mem_stage: memory-access stage, one outstanding single-beat data access.
// Optional misaligned-access trap enabled by defining MA_MISALIGN_TRAP_EN.
module ma_mem_stage #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  halt,
  input  logic                  flush,
  input  logic                  is_mem_in,
  input  logic                  is_load_in,
  input  logic [1:0]            mem_size_in,
  input  logic                  mem_signed_in,
  input  logic [ADDR_W-1:0]     mem_addr_in,
  input  logic [DATA_W-1:0]     store_data_in,
  input  logic                  is_int_wb_in,
  input  logic [REG_ADDR_W-1:0] int_wb_address_in,
  input  logic [DATA_W-1:0]     int_wb_value_in,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [ADDR_W-1:0]     dmem_addr,
  output logic [DATA_W-1:0]     dmem_wdata,
  output logic [DATA_W/8-1:0]   dmem_be,
  input  logic [DATA_W-1:0]     dmem_rdata,
  input  logic                  dmem_ack,
  output logic                  stall_out,
  output logic                  is_mem_out,
  output logic                  is_int_wb_out,
  output logic [REG_ADDR_W-1:0] int_wb_address_out,
  output logic [DATA_W-1:0]     int_wb_value_out
`ifdef MA_MISALIGN_TRAP_EN
  ,
  output logic                  misalign_out
`endif
);

  localparam int BE_W   = DATA_W / 8;
  localparam int LANE_W = $clog2(BE_W);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t state, state_n;

  logic accept, pass, bubble, retire;
  logic stash, drain, trap, clear;

  logic [ADDR_W-1:0]     eff_addr;
  logic [LANE_W-1:0]     lane;
  logic [DATA_W-1:0]     st_data;
  logic [BE_W-1:0]       st_be;

  logic                  l_load;
  logic                  l_signed;
  logic [1:0]            l_size;
  logic [LANE_W-1:0]     l_lane;
  logic [REG_ADDR_W-1:0] l_rd;
  logic [DATA_W-1:0]     buf_val;

  logic [DATA_W-1:0]     ld_shift;
  logic [DATA_W-1:0]     ld_mask;
  logic [DATA_W-1:0]     ld_val;
  logic                  ld_sign;

  assign stall_out = (state != IDLE);

  // Size-aligned address; sub-size bits are dropped.
  always_comb begin
    eff_addr = mem_addr_in;
    unique case (1'b1)
      mem_size_in == 2'b00: eff_addr = mem_addr_in;
      mem_size_in == 2'b01: eff_addr[0] = 1'b0;
      default:              eff_addr[1:0] = 2'b00;
    endcase
  end

  assign lane = eff_addr[LANE_W-1:0];

  always_comb begin
    st_data = '0;
    st_be   = '0;
    unique case (1'b1)
      mem_size_in == 2'b00: begin
        st_data = {BE_W{store_data_in[7:0]}};
        st_be   = BE_W'(1) << lane;
      end
      mem_size_in == 2'b01: begin
        st_data = {(BE_W/2){store_data_in[15:0]}};
        st_be   = BE_W'(3) << lane;
      end
      default: begin
        st_data = {(BE_W/4){store_data_in[31:0]}};
        st_be   = BE_W'(15) << lane;
      end
    endcase
  end

  assign ld_shift = dmem_rdata >> {l_lane, 3'b000};

  always_comb begin
    ld_mask = '0;
    ld_sign = 1'b0;
    unique case (l_size)
      2'b00: begin
        ld_mask = DATA_W'(8'hFF);
        ld_sign = ld_shift[7];
      end
      2'b01: begin
        ld_mask = DATA_W'(16'hFFFF);
        ld_sign = ld_shift[15];
      end
      default: begin
        ld_mask = DATA_W'(32'hFFFF_FFFF);
        ld_sign = ld_shift[31];
      end
    endcase
    ld_val = (ld_shift & ld_mask)
           | ({DATA_W{l_signed & ld_sign}} & ~ld_mask);
  end

`ifdef MA_MISALIGN_TRAP_EN
  logic misalign;
  assign misalign = (mem_size_in == 2'b01) ? mem_addr_in[0]
                  : (mem_size_in[1] && (|mem_addr_in[1:0]));
`endif

  always_comb begin
    state_n = state;
    accept  = 1'b0;
    pass    = 1'b0;
    bubble  = 1'b0;
    retire  = 1'b0;
    stash   = 1'b0;
    drain   = 1'b0;
    trap    = 1'b0;
    unique case (state)
      IDLE: begin
        if (!halt) begin
          if (flush) begin
            bubble = 1'b1;
          end else if (!is_mem_in) begin
            pass = 1'b1;
`ifdef MA_MISALIGN_TRAP_EN
          end else if (misalign) begin
            trap = 1'b1;
`endif
          end else begin
            accept  = 1'b1;
            state_n = ACCESS;
          end
        end
      end
      ACCESS: begin
        if (!dmem_ack) begin
          bubble = 1'b1;
        end else if (halt) begin
          stash   = 1'b1;
          state_n = DONE;
        end else begin
          retire  = 1'b1;
          state_n = IDLE;
        end
      end
      DONE: begin
        if (!halt) begin
          drain   = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign clear = bubble | accept | stash | trap;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      dmem_be    <= '0;
      l_load     <= 1'b0;
      l_signed   <= 1'b0;
      l_size     <= '0;
      l_lane     <= '0;
      l_rd       <= '0;
      buf_val    <= '0;
    end else if (accept) begin
      dmem_req   <= 1'b1;
      dmem_we    <= !is_load_in;
      dmem_addr  <= {eff_addr[ADDR_W-1:LANE_W], {LANE_W{1'b0}}};
      dmem_wdata <= is_load_in ? '0 : st_data;
      dmem_be    <= st_be;
      l_load     <= is_load_in;
      l_signed   <= mem_signed_in;
      l_size     <= mem_size_in;
      l_lane     <= lane;
      l_rd       <= int_wb_address_in;
    end else if (retire || stash) begin
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      dmem_be    <= '0;
      if (stash) buf_val <= l_load ? ld_val : '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      is_mem_out         <= 1'b0;
      is_int_wb_out      <= 1'b0;
      int_wb_address_out <= '0;
      int_wb_value_out   <= '0;
    end else if (pass) begin
      is_mem_out         <= 1'b0;
      is_int_wb_out      <= is_int_wb_in;
      int_wb_address_out <= int_wb_address_in;
      int_wb_value_out   <= int_wb_value_in;
    end else if (retire || drain) begin
      is_mem_out         <= 1'b1;
      is_int_wb_out      <= l_load;
      int_wb_address_out <= l_load ? l_rd : '0;
      int_wb_value_out   <= drain ? buf_val
                          : (l_load ? ld_val : '0);
    end else if (clear) begin
      is_mem_out         <= 1'b0;
      is_int_wb_out      <= 1'b0;
      int_wb_address_out <= '0;
      int_wb_value_out   <= '0;
    end
  end

`ifdef MA_MISALIGN_TRAP_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                       misalign_out <= 1'b0;
    else if (!halt || state != IDLE)  misalign_out <= trap;
  end
`endif

endmodule

// File: tb/tb_ma_mem_stage.sv
// tb_ma_mem_stage: table-driven vectors with a result scoreboard queue.
// Build with MA_MISALIGN_TRAP_EN to exercise the trap path.
module tb_ma_mem_stage;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int RW = 5;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          halt = 1'b0;
  logic          flush = 1'b0;
  logic          is_mem_in = 1'b0;
  logic          is_load_in = 1'b0;
  logic [1:0]    mem_size_in = '0;
  logic          mem_signed_in = 1'b0;
  logic [AW-1:0] mem_addr_in = '0;
  logic [DW-1:0] store_data_in = '0;
  logic          is_int_wb_in = 1'b0;
  logic [RW-1:0] int_wb_address_in = '0;
  logic [DW-1:0] int_wb_value_in = '0;
  logic          dmem_req;
  logic          dmem_we;
  logic [AW-1:0] dmem_addr;
  logic [DW-1:0] dmem_wdata;
  logic [DW/8-1:0] dmem_be;
  logic [DW-1:0] dmem_rdata = '0;
  logic          dmem_ack = 1'b0;
  logic          stall_out;
  logic          is_mem_out;
  logic          is_int_wb_out;
  logic [RW-1:0] int_wb_address_out;
  logic [DW-1:0] int_wb_value_out;
`ifdef MA_MISALIGN_TRAP_EN
  logic          misalign_out;
`endif

  ma_mem_stage #(.DATA_W(DW), .ADDR_W(AW), .REG_ADDR_W(RW)) dut (
    .clk(clk),
    .reset(reset),
    .halt(halt),
    .flush(flush),
    .is_mem_in(is_mem_in),
    .is_load_in(is_load_in),
    .mem_size_in(mem_size_in),
    .mem_signed_in(mem_signed_in),
    .mem_addr_in(mem_addr_in),
    .store_data_in(store_data_in),
    .is_int_wb_in(is_int_wb_in),
    .int_wb_address_in(int_wb_address_in),
    .int_wb_value_in(int_wb_value_in),
    .dmem_req(dmem_req),
    .dmem_we(dmem_we),
    .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata),
    .dmem_be(dmem_be),
    .dmem_rdata(dmem_rdata),
    .dmem_ack(dmem_ack),
    .stall_out(stall_out),
    .is_mem_out(is_mem_out),
    .is_int_wb_out(is_int_wb_out),
    .int_wb_address_out(int_wb_address_out),
    .int_wb_value_out(int_wb_value_out)
`ifdef MA_MISALIGN_TRAP_EN
    ,
    .misalign_out(misalign_out)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        mem;
    logic        wb;
    logic [4:0]  rd;
    logic [31:0] val;
  } res_t;

  typedef struct {
    logic        h;
    logic        f;
    logic        wb;
    logic [4:0]  rd;
    logic [31:0] v;
    res_t        want;
  } alu_vec_t;

  typedef struct {
    logic        ld;
    logic [1:0]  sz;
    logic        sg;
    logic [31:0] addr;
    logic [31:0] sd;
    logic [31:0] rdata;
    logic [4:0]  rd;
    logic [31:0] xaddr;
    logic [3:0]  xbe;
    logic [31:0] xwd;
    logic [31:0] xval;
    int          dly;
  } mem_vec_t;

  res_t     sb[$];
  alu_vec_t av[6];
  mem_vec_t mv[$];
  int       passed = 0;
  int       total = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] want);
    total++;
    if (act === want) passed++;
    else $display("FAIL %s: actual=%h required=%h", nm, act, want);
  endtask

  task automatic check_out(input string nm);
    res_t e;
    logic ok;
    total++;
    if (sb.size() == 0) begin
      $display("FAIL %s: scoreboard empty", nm);
      return;
    end
    e  = sb.pop_front();
    ok = (is_mem_out === e.mem) && (is_int_wb_out === e.wb);
    if (e.wb || e.mem) ok = ok && (int_wb_address_out === e.rd);
    if (e.wb) ok = ok && (int_wb_value_out === e.val);
    if (ok) passed++;
    else $display("FAIL %s: actual mem=%b wb=%b rd=%0d val=%h required mem=%b wb=%b rd=%0d val=%h",
                  nm, is_mem_out, is_int_wb_out, int_wb_address_out,
                  int_wb_value_out, e.mem, e.wb, e.rd, e.val);
  endtask

  task automatic idle_in();
    halt = 1'b0;
    flush = 1'b0;
    is_mem_in = 1'b0;
    is_load_in = 1'b0;
    mem_size_in = '0;
    mem_signed_in = 1'b0;
    mem_addr_in = '0;
    store_data_in = '0;
    is_int_wb_in = 1'b0;
    int_wb_address_in = '0;
    int_wb_value_in = '0;
  endtask

  task automatic drive_mem(input logic ld, input logic [1:0] sz,
                           input logic sg, input logic [31:0] a,
                           input logic [31:0] sd, input logic [4:0] rd);
    idle_in();
    is_mem_in = 1'b1;
    is_load_in = ld;
    mem_size_in = sz;
    mem_signed_in = sg;
    mem_addr_in = a;
    store_data_in = sd;
    is_int_wb_in = ld;
    int_wb_address_in = rd;
    int_wb_value_in = 32'h5A5A_5A5A;
  endtask

  task automatic run_mem(input mem_vec_t m, input string nm);
    logic stable;
    int   stalls;
    drive_mem(m.ld, m.sz, m.sg, m.addr, m.sd, m.rd);
    sb.push_back('{1'b1, m.ld, (m.ld ? m.rd : 5'd0), m.xval});
    tick();
    flush = 1'b1;
    mem_addr_in = 32'hFFFF_FFFF;
    store_data_in = 32'h0F0F_0F0F;
    int_wb_address_in = 5'd31;
    chk({nm, "_req"}, {31'd0, dmem_req, dmem_we, dmem_addr},
        {31'd0, 1'b1, !m.ld, m.xaddr});
    if (!m.ld)
      chk({nm, "_lanes"}, {28'd0, dmem_be, dmem_wdata}, {28'd0, m.xbe, m.xwd});
    stable = 1'b1;
    stalls = 0;
    for (int k = 0; k <= m.dly; k++) begin
      if (stall_out === 1'b1) stalls++;
      stable = stable && (dmem_req === 1'b1) && (dmem_addr === m.xaddr)
             && (dmem_we === !m.ld)
             && (m.ld || ((dmem_be === m.xbe) && (dmem_wdata === m.xwd)));
      if (k == m.dly) begin
        dmem_ack = 1'b1;
        dmem_rdata = m.rdata;
      end
      tick();
    end
    dmem_ack = 1'b0;
    dmem_rdata = '0;
    idle_in();
    chk({nm, "_stall_cycles"}, 64'(stalls), 64'(m.dly + 1));
    chk({nm, "_bus_stable"}, {63'd0, stable}, 64'd1);
    chk({nm, "_released"}, {62'd0, dmem_req, stall_out}, 64'd0);
    check_out(nm);
  endtask

  initial begin
    av[0] = '{1'b0, 1'b0, 1'b1, 5'd5, 32'h0000_1234,
              '{1'b0, 1'b1, 5'd5, 32'h0000_1234}};
    av[1] = '{1'b1, 1'b0, 1'b1, 5'd9, 32'h0000_9999,
              '{1'b0, 1'b1, 5'd5, 32'h0000_1234}};
    av[2] = '{1'b0, 1'b1, 1'b1, 5'd9, 32'h0000_9999,
              '{1'b0, 1'b0, 5'd0, 32'h0}};
    av[3] = '{1'b0, 1'b0, 1'b1, 5'd31, 32'hFFFF_FFFF,
              '{1'b0, 1'b1, 5'd31, 32'hFFFF_FFFF}};
    av[4] = '{1'b1, 1'b1, 1'b0, 5'd2, 32'h0000_0002,
              '{1'b0, 1'b1, 5'd31, 32'hFFFF_FFFF}};
    av[5] = '{1'b0, 1'b0, 1'b0, 5'd3, 32'h0000_0055,
              '{1'b0, 1'b0, 5'd0, 32'h0}};

    mv.push_back('{1'b1, 2'b00, 1'b1, 32'h103, 32'h0, 32'h8012_3456, 5'd10,
                   32'h100, 4'h0, 32'h0, 32'hFFFF_FF80, 3});
    mv.push_back('{1'b1, 2'b00, 1'b0, 32'h103, 32'h0, 32'h8012_3456, 5'd11,
                   32'h100, 4'h0, 32'h0, 32'h0000_0080, 1});
    mv.push_back('{1'b1, 2'b01, 1'b1, 32'h102, 32'h0, 32'h8001_7F00, 5'd12,
                   32'h100, 4'h0, 32'h0, 32'hFFFF_8001, 0});
    mv.push_back('{1'b1, 2'b01, 1'b0, 32'h100, 32'h0, 32'h1234_F00D, 5'd13,
                   32'h100, 4'h0, 32'h0, 32'h0000_F00D, 2});
    mv.push_back('{1'b1, 2'b10, 1'b1, 32'h104, 32'h0, 32'hDEAD_BEEF, 5'd14,
                   32'h104, 4'h0, 32'h0, 32'hDEAD_BEEF, 1});
    mv.push_back('{1'b0, 2'b01, 1'b0, 32'h102, 32'h1234_BEEF, 32'h0, 5'd6,
                   32'h100, 4'b1100, 32'hBEEF_BEEF, 32'h0, 2});
    mv.push_back('{1'b0, 2'b00, 1'b0, 32'h101, 32'hFFFF_FFA5, 32'h0, 5'd6,
                   32'h100, 4'b0010, 32'hA5A5_A5A5, 32'h0, 0});
    mv.push_back('{1'b0, 2'b10, 1'b0, 32'h104, 32'h1234_5678, 32'h0, 5'd6,
                   32'h104, 4'b1111, 32'h1234_5678, 32'h0, 1});
`ifndef MA_MISALIGN_TRAP_EN
    mv.push_back('{1'b1, 2'b10, 1'b0, 32'h102, 32'h0, 32'h1122_3344, 5'd15,
                   32'h100, 4'h0, 32'h0, 32'h1122_3344, 1});
    mv.push_back('{1'b1, 2'b11, 1'b1, 32'h10B, 32'h0, 32'hA0B0_C0D0, 5'd16,
                   32'h108, 4'h0, 32'h0, 32'hA0B0_C0D0, 0});
`endif

    #1 reset = 1'b0;
    #2;
`ifdef MA_MISALIGN_TRAP_EN
    chk("reset_trap", {63'd0, misalign_out}, 64'd0);
`endif
    chk("reset_outputs",
        {dmem_req, dmem_we, dmem_addr[15:0], dmem_be, stall_out, is_mem_out,
         is_int_wb_out, int_wb_address_out, int_wb_value_out[7:0]}, 64'd0);
    @(posedge clk);
    #1 reset = 1'b1;

    for (int i = 0; i < 6; i++) begin
      idle_in();
      halt = av[i].h;
      flush = av[i].f;
      is_int_wb_in = av[i].wb;
      int_wb_address_in = av[i].rd;
      int_wb_value_in = av[i].v;
      sb.push_back(av[i].want);
      tick();
      check_out($sformatf("alu_vec%0d", i));
    end
    idle_in();

    foreach (mv[i]) run_mem(mv[i], $sformatf("mem_vec%0d", i));

    // result produced while halted is held in DONE until release
    drive_mem(1'b1, 2'b10, 1'b0, 32'h108, 32'h0, 5'd7);
    sb.push_back('{1'b1, 1'b1, 5'd7, 32'hCAFE_F00D});
    tick();
    idle_in();
    chk("halt_req", {63'd0, dmem_req}, 64'd1);
    tick();
    dmem_ack = 1'b1;
    dmem_rdata = 32'hCAFE_F00D;
    halt = 1'b1;
    tick();
    dmem_ack = 1'b0;
    dmem_rdata = '0;
    chk("halt_done", {61'd0, stall_out, dmem_req, is_mem_out}, 64'b100);
    tick();
    chk("halt_hold", {62'd0, stall_out, is_mem_out}, 64'b10);
    halt = 1'b0;
    tick();
    check_out("halt_drain");
    chk("halt_idle", {63'd0, stall_out}, 64'd0);

    // flush squashes a presented load
    idle_in();
    is_int_wb_in = 1'b1;
    int_wb_address_in = 5'd3;
    int_wb_value_in = 32'h77;
    sb.push_back('{1'b0, 1'b1, 5'd3, 32'h77});
    tick();
    check_out("pre_flush");
    drive_mem(1'b1, 2'b10, 1'b0, 32'h200, 32'h0, 5'd4);
    flush = 1'b1;
    sb.push_back('{1'b0, 1'b0, 5'd0, 32'h0});
    tick();
    idle_in();
    check_out("flush_bubble");
    chk("flush_noreq", {62'd0, dmem_req, stall_out}, 64'd0);

    // async reset mid-access, then a stray ack is ignored
    drive_mem(1'b1, 2'b10, 1'b0, 32'h300, 32'h0, 5'd9);
    tick();
    idle_in();
    chk("rst_pre_req", {63'd0, dmem_req}, 64'd1);
    #2 reset = 1'b0;
    #1;
    chk("rst_async",
        {dmem_req, dmem_we, dmem_addr[15:0], dmem_be, stall_out, is_mem_out,
         is_int_wb_out, int_wb_address_out, int_wb_value_out[7:0]}, 64'd0);
    #2 reset = 1'b1;
    dmem_ack = 1'b1;
    dmem_rdata = 32'h1357_9BDF;
    tick();
    dmem_ack = 1'b0;
    chk("rst_stray_ack",
        {60'd0, is_mem_out, is_int_wb_out, stall_out, dmem_req}, 64'd0);

`ifdef MA_MISALIGN_TRAP_EN
    drive_mem(1'b1, 2'b10, 1'b0, 32'h102, 32'h0, 5'd8);
    tick();
    idle_in();
    chk("mis_lw_trap",
        {59'd0, misalign_out, dmem_req, stall_out, is_mem_out, is_int_wb_out},
        64'b10000);
    tick();
    chk("mis_lw_clear", {62'd0, misalign_out, dmem_req}, 64'd0);
    drive_mem(1'b0, 2'b01, 1'b0, 32'h101, 32'h1111, 5'd0);
    tick();
    idle_in();
    chk("mis_sh_trap", {61'd0, misalign_out, dmem_req, stall_out}, 64'b100);
    tick();
    chk("mis_sh_clear", {63'd0, misalign_out}, 64'd0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
